// File: rtl/mant_normalizer.sv
// mant_normalizer: multi-cycle left-shift normalizer for 8-bit mantissa/exponent
// pairs. Shifts one bit per cycle until bit 7 is set, decrementing the exponent,
// and stops early on a zero mantissa or when the exponent reaches 0.
module mant_normalizer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] MantIn,
  input  logic [7:0] ExpIn,
  output logic       Done,
  output logic [7:0] MantOut,
  output logic [7:0] ExpOut,
  output logic [2:0] ShiftCnt,
  output logic       Zero,
  output logic       Underflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [7:0] mant_q,  mant_d;
  logic [7:0] exp_q,   exp_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       zero_q,  zero_d;
  logic       uf_q,    uf_d;
  logic       launch;

  always_comb begin
    launch  = Start & ~start_q;
    start_d = Start;
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    uf_d    = uf_q;

    case (state_q)
      // A launch is accepted from IDLE and from DONE; results otherwise hold.
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          mant_d  = MantIn;
          exp_d   = ExpIn;
          cnt_d   = '0;
          zero_d  = 1'b0;
          uf_d    = 1'b0;
          state_d = ST_SHIFT;
        end
      end

      // Termination checks in priority order; otherwise one shift step.
      ST_SHIFT: begin
        if (mant_q == '0) begin
          zero_d  = 1'b1;
          exp_d   = '0;
          state_d = ST_DONE;
        end else if (mant_q[7]) begin
          state_d = ST_DONE;
        end else if (exp_q == '0) begin
          uf_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          mant_d = {mant_q[6:0], 1'b0};
          exp_d  = exp_q - 8'd1;
          cnt_d  = cnt_q + 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
    end
  end

  assign Done      = (state_q == ST_DONE);
  assign MantOut   = mant_q;
  assign ExpOut    = exp_q;
  assign ShiftCnt  = cnt_q;
  assign Zero      = zero_q;
  assign Underflow = uf_q;

endmodule

// File: tb/tb_mant_normalizer.sv
// Self-checking bench for mant_normalizer: hand-written vector table, directed
// handshake/reset sequences, and randomized operands against a closed-form model.
module tb_mant_normalizer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] MantIn;
  logic [7:0] ExpIn;
  logic       Done;
  logic [7:0] MantOut;
  logic [7:0] ExpOut;
  logic [2:0] ShiftCnt;
  logic       Zero;
  logic       Underflow;

  int n_vec = 0;
  int n_err = 0;

  mant_normalizer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .MantIn    (MantIn),
    .ExpIn     (ExpIn),
    .Done      (Done),
    .MantOut   (MantOut),
    .ExpOut    (ExpOut),
    .ShiftCnt  (ShiftCnt),
    .Zero      (Zero),
    .Underflow (Underflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] m;
    logic [7:0] e;
    logic [7:0] xm;
    logic [7:0] xe;
    int         xc;
    logic       xz;
    logic       xu;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Closed form: shift count is min(leading zeros, exponent).
  function automatic void model(input logic [7:0] m, input logic [7:0] e,
                                output logic [7:0] om, output logic [7:0] oe,
                                output int oc, output logic oz, output logic ou,
                                output int lat);
    int msb;
    int lz;
    int s;
    if (m == 8'd0) begin
      om = 8'd0; oe = 8'd0; oc = 0; oz = 1'b1; ou = 1'b0; lat = 1;
      return;
    end
    msb = 0;
    for (int i = 0; i < 8; i++)
      if ((int'(m) >> i) != 0) msb = i;
    lz  = 7 - msb;
    s   = (lz < int'(e)) ? lz : int'(e);
    om  = 8'((int'(m) << s) & 255);
    oe  = 8'(int'(e) - s);
    oc  = s;
    oz  = 1'b0;
    ou  = (lz > int'(e));
    lat = s + 1;
  endfunction

  task automatic launch(input logic [7:0] m, input logic [7:0] e);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    MantIn = m;
    ExpIn  = e;
    Start  = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int lat);
    lat = 0;
    while (Done !== 1'b1 && lat < 20) begin
      if (noise) begin
        Start  = 1'($urandom);
        MantIn = 8'($urandom);
        ExpIn  = 8'($urandom);
      end
      @(posedge Clk);
      #1;
      lat++;
    end
    if (noise) Start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] xm, input logic [7:0] xe,
                              input int xc, input logic xz, input logic xu,
                              input int xlat, input int lat);
    chk({tag, ".latency"},   lat,          xlat);
    chk({tag, ".Done"},      int'(Done),   1);
    chk({tag, ".MantOut"},   int'(MantOut), int'(xm));
    chk({tag, ".ExpOut"},    int'(ExpOut), int'(xe));
    chk({tag, ".ShiftCnt"},  int'(ShiftCnt), xc);
    chk({tag, ".Zero"},      int'(Zero),   int'(xz));
    chk({tag, ".Underflow"}, int'(Underflow), int'(xu));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".Done"},      int'(Done),      0);
    chk({tag, ".MantOut"},   int'(MantOut),   0);
    chk({tag, ".ExpOut"},    int'(ExpOut),    0);
    chk({tag, ".ShiftCnt"},  int'(ShiftCnt),  0);
    chk({tag, ".Zero"},      int'(Zero),      0);
    chk({tag, ".Underflow"}, int'(Underflow), 0);
  endtask

  initial begin
    vec_t       tbl[10];
    int         lat;
    int         drops;
    logic [7:0] rm, re, om, oe;
    int         oc, olat;
    logic       oz, ou;

    //         m      e      xm     xe     xc xz    xu    lat
    tbl[0] = '{8'h3F, 8'd8,  8'hFC, 8'd6,  2, 1'b0, 1'b0, 3};
    tbl[1] = '{8'h80, 8'd5,  8'h80, 8'd5,  0, 1'b0, 1'b0, 1};
    tbl[2] = '{8'h00, 8'd9,  8'h00, 8'd0,  0, 1'b1, 1'b0, 1};
    tbl[3] = '{8'h01, 8'd3,  8'h08, 8'd0,  3, 1'b0, 1'b1, 4};
    tbl[4] = '{8'h01, 8'd10, 8'h80, 8'd3,  7, 1'b0, 1'b0, 8};
    tbl[5] = '{8'h40, 8'd1,  8'h80, 8'd0,  1, 1'b0, 1'b0, 2};
    tbl[6] = '{8'h01, 8'd0,  8'h01, 8'd0,  0, 1'b0, 1'b1, 1};
    tbl[7] = '{8'hFF, 8'd0,  8'hFF, 8'd0,  0, 1'b0, 1'b0, 1};
    tbl[8] = '{8'h10, 8'd2,  8'h40, 8'd0,  2, 1'b0, 1'b1, 3};
    tbl[9] = '{8'h10, 8'd3,  8'h80, 8'd0,  3, 1'b0, 1'b0, 4};

    Reset = 1'b1; Start = 1'b0; MantIn = '0; ExpIn = '0;
    repeat (3) @(posedge Clk);
    #1;
    check_cleared("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Vector table; consecutive launches come from DONE.
    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].m, tbl[i].e);
      chk($sformatf("tbl%0d.done_drop", i), int'(Done), 0);
      wait_done(1'b0, lat);
      check_result($sformatf("tbl%0d", i), tbl[i].xm, tbl[i].xe, tbl[i].xc,
                   tbl[i].xz, tbl[i].xu, tbl[i].lat, lat);
    end

    // Start held through reset and beyond: exactly one run.
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b1; MantIn = 8'h01; ExpIn = 8'd10;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk("hs.done_after_e0", int'(Done), 0);
    wait_done(1'b0, lat);
    check_result("hs.run1", 8'h80, 8'd3, 7, 1'b0, 1'b0, 8, lat);
    drops = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk);
      #1;
      if (Done !== 1'b1 || MantOut !== 8'h80) drops++;
    end
    chk("hs.no_relaunch", drops, 0);
    launch(8'h40, 8'd1);
    chk("hs.run2.done_drop", int'(Done), 0);
    wait_done(1'b0, lat);
    check_result("hs.run2", 8'h80, 8'd0, 1, 1'b0, 1'b0, 2, lat);

    // Reset mid-shift discards the partial result.
    launch(8'h02, 8'd10);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check_cleared("midreset");
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("midreset.idle_done", int'(Done), 0);
    launch(8'h02, 8'd10);
    wait_done(1'b0, lat);
    check_result("midreset.rerun", 8'h80, 8'd4, 6, 1'b0, 1'b0, 7, lat);

    // Random operands with Start/operand noise while shifting.
    for (int r = 0; r < 200; r++) begin
      rm = 8'($urandom) >> $urandom_range(0, 7);
      re = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      model(rm, re, om, oe, oc, oz, ou, olat);
      launch(rm, re);
      chk($sformatf("rnd%0d.done_drop", r), int'(Done), 0);
      wait_done(1'b1, lat);
      check_result($sformatf("rnd%0d(m=%0d,e=%0d)", r, rm, re), om, oe, oc, oz, ou, olat, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
